tug_cpu_center: RTL and testbench

TUG_CPU_CENTER -- requirements
Module: tug_cpu_center

---
 rtl/tug_cpu_center.sv | 128 ++++++++++++
 tb/tb_tug_cpu_center.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tug_cpu_center.sv
`default_nettype none
// ============================================================================
// Module      : tug_cpu_center
// Description : Center light of a tug-of-war game plus a CPU opponent.
//               A 10-bit XNOR LFSR (taps 10,7) produces a pseudo-random value;
//               the CPU requests a press when the threshold exceeds it.
//               The center light FSM reacts to player pulls and neighbour
//               lights only; the CPU press is fed back externally.
//
//   Ports:
//     clk            in   rising-edge clock for all state
//     reset          in   synchronous, active-high reset
//     threshold[8:0] in   CPU aggressiveness (unsigned)
//     L, R           in   left / right player pull pulses
//     NL, NR         in   left / right neighbour light is on
//     lfsr_out[9:0]  out  current LFSR state
//     computerInput  out  CPU press request
//     lightOn        out  center light state
//
//   Parameters:
//     RESET_SEED     LFSR reset value (10'h3FF is the lock-up state, illegal)
//
//   Configuration macro:
//     TUG_CPU_CMP_REG_EN  defined   -> computerInput registered (1-cycle
//                                      latency, resets to 0)
//                         undefined -> computerInput combinational
//
// Revision    : 1.0 - initial release
// ============================================================================
module tug_cpu_center #(
    parameter logic [9:0] RESET_SEED = 10'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] threshold,
    input  logic       L,
    input  logic       R,
    input  logic       NL,
    input  logic       NR,
    output logic [9:0] lfsr_out,
    output logic       computerInput,
    output logic       lightOn
);

    // Light FSM encoding
    localparam logic [0:0] c_ST_OFF = 1'b0;
    localparam logic [0:0] c_ST_ON  = 1'b1;

    logic [9:0] r_lfsr;
    logic       w_lfsr_fb;
    logic       w_cmp;
    logic [0:0] r_state;
    logic [0:0] w_state_next;

    // ------------------------------------------------------------------------
    // LFSR: XNOR feedback makes all-ones the lock-up state, so the all-zero
    // seed is a legal starting point.
    // ------------------------------------------------------------------------
    assign w_lfsr_fb = ~(r_lfsr[9] ^ r_lfsr[6]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= RESET_SEED;
        end else begin
            r_lfsr <= {r_lfsr[8:0], w_lfsr_fb};
        end
    end

    assign lfsr_out = r_lfsr;

    // ------------------------------------------------------------------------
    // Comparator: zero-extend threshold so 9'h1FF never beats LFSR values
    // at or above 10'h1FF.
    // ------------------------------------------------------------------------
    assign w_cmp = ({1'b0, threshold} > r_lfsr);

`ifdef TUG_CPU_CMP_REG_EN
    logic r_cmp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp <= 1'b0;
        end else begin
            r_cmp <= w_cmp;
        end
    end

    assign computerInput = r_cmp;
`else
    assign computerInput = w_cmp;
`endif

    // ------------------------------------------------------------------------
    // Center light FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_ON;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_ON: begin
                // A single pull drags the light off-center; equal pulls cancel.
                if (L ^ R) begin
                    w_state_next = c_ST_OFF;
                end
            end
            c_ST_OFF: begin
                // Light returns only when pulled back from the lit neighbour.
                if ((NR & L & ~R) | (NL & R & ~L)) begin
                    w_state_next = c_ST_ON;
                end
            end
            default: begin
                w_state_next = c_ST_ON;
            end
        endcase
    end

    assign lightOn = (r_state == c_ST_ON);

endmodule
`default_nettype wire

// File: tb/tb_tug_cpu_center.sv
`default_nettype none
// ============================================================================
// Module      : tb_tug_cpu_center
// Description : Self-checking bench for tug_cpu_center. Table-driven LFSR,
//               comparator and light-FSM vectors plus free-run period checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_cpu_center;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] threshold = 9'h000;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic       NL = 1'b0;
    logic       NR = 1'b0;
    logic [9:0] lfsr_out;
    logic       computerInput;
    logic       lightOn;

    int n_checks = 0;
    int n_fail   = 0;

    tug_cpu_center dut (
        .clk           (clk),
        .reset         (reset),
        .threshold     (threshold),
        .L             (L),
        .R             (R),
        .NL            (NL),
        .NR            (NR),
        .lfsr_out      (lfsr_out),
        .computerInput (computerInput),
        .lightOn       (lightOn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic l;
        logic r;
        logic nl;
        logic nr;
        logic exp_light;
    } light_vec_t;

    light_vec_t  lv [10];
    logic [9:0]  seq_exp [9];
    logic        cmp_exp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        L = 1'b0; R = 1'b0; NL = 1'b0; NR = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [9:0] lfsr_next(input logic [9:0] q);
        return {q[8:0], ~(q[9] ^ q[6])};
    endfunction

    initial begin
        logic [1023:0] seen;
        logic [9:0]    model;
        int            dup, saw_3ff, hi, model_err;

        // Hand-computed LFSR sequence from the 000 seed
        seq_exp = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                    10'h01F, 10'h03F, 10'h07F, 10'h0FE};

        // threshold = 3 sampled at lfsr 000, 001, 003, 007
`ifdef TUG_CPU_CMP_REG_EN
        cmp_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        cmp_exp = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif

        // Light vectors starting from ON: {L, R, NL, NR, expected lightOn}
        lv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        lv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        lv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        lv[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        lv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        lv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        lv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        lv[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        lv[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        tick();
        reset = 1'b0;
        check("reset_lfsr", 32'(lfsr_out), 32'h000);
        check("reset_light", 32'(lightOn), 32'h1);
        check("reset_cpu", 32'(computerInput), 32'h0);

        // First nine LFSR values
        for (int i = 0; i < 9; i++) begin
            check($sformatf("lfsr_seq[%0d]", i), 32'(lfsr_out), 32'(seq_exp[i]));
            tick();
        end

        // Full period with threshold 1FF
        threshold = 9'h1FF;
        do_reset();
        seen = '0; dup = 0; saw_3ff = 0; hi = 0; model_err = 0; model = 10'h000;
        for (int i = 0; i < 1023; i++) begin
            if (lfsr_out !== model) model_err++;
            if (seen[lfsr_out]) dup++;
            seen[lfsr_out] = 1'b1;
            if (lfsr_out == 10'h3FF) saw_3ff++;
            if (computerInput) hi++;
            model = lfsr_next(model);
            tick();
        end
        check("period_model_errors", 32'(model_err), 32'h0);
        check("period_wrap_to_000", 32'(lfsr_out), 32'h000);
        check("period_duplicates", 32'(dup), 32'h0);
        check("period_saw_3ff", 32'(saw_3ff), 32'h0);
        check("thr_1ff_high_count", 32'(hi), 32'd511);

        // Full period with threshold 0: CPU never presses
        threshold = 9'h000;
        do_reset();
        hi = 0;
        for (int i = 0; i < 1023; i++) begin
            if (computerInput) hi++;
            tick();
        end
        check("thr_0_high_count", 32'(hi), 32'd0);

        // Comparator boundary around equality
        threshold = 9'h003;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cmp_thr3[%0d]", i), 32'(computerInput), 32'(cmp_exp[i]));
            tick();
        end
        threshold = 9'h000;

        // Light FSM table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            L = lv[i].l; R = lv[i].r; NL = lv[i].nl; NR = lv[i].nr;
            tick();
            check($sformatf("light_vec[%0d]", i), 32'(lightOn), 32'(lv[i].exp_light));
        end

        // Reset while OFF with both pulls asserted
        L = 1'b1; R = 1'b0; NL = 1'b0; NR = 1'b0;
        tick();
        check("off_before_reset", 32'(lightOn), 32'h0);
        reset = 1'b1; L = 1'b1; R = 1'b1; NL = 1'b1; NR = 1'b1;
        tick();
        check("reset_from_off", 32'(lightOn), 32'h1);

        // Reset priority over a pull from ON, mid-run LFSR
        reset = 1'b0; L = 1'b0; R = 1'b0; NL = 1'b0; NR = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; L = 1'b1; R = 1'b0;
        tick();
        check("reset_prio_light", 32'(lightOn), 32'h1);
        check("reset_prio_lfsr", 32'(lfsr_out), 32'h000);
        reset = 1'b0; L = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
